// File: rtl/rv_iommu.sv
// Shared IOMMU definitions used by the WSI gateway: wire-count ceiling and claim ID width helper.
package rv_iommu;

  localparam int MAX_WSI_WIRES = 63;

  // ID 0 is reserved for "no interrupt", so IDs span 0..n_wires.
  function automatic int wsi_gw_id_w(input int n_wires);
    return $clog2(n_wires + 1);
  endfunction

endpackage

// File: rtl/iommu_wsi_gw_cell.sv
// Per-wire gateway cell: level capture into pending, claim moves pending to in_service.
module iommu_wsi_gw_cell (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pending,
  output logic in_service
);

  // claim_hit only fires on a pending bit and complete_hit only on an in-service bit,
  // so the two never land on the same cell in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else if (claim_hit) begin
      pending    <= 1'b0;
      in_service <= 1'b1;
    end else begin
      if (complete_hit) in_service <= 1'b0;
      if (level && !pending && !in_service) pending <= 1'b1;
    end
  end

endmodule

// File: rtl/iommu_wsi_gateway.sv
// WSI wire-to-claim/complete gateway with fixed lowest-index priority.
// Build option: IOMMU_WSI_GW_SYNC_EN adds a 2-flop synchronizer ahead of the input register.
module iommu_wsi_gateway
  import rv_iommu::*;
#(
  parameter int N_WIRES = 16,
  parameter int ID_W    = wsi_gw_id_w(N_WIRES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_WIRES-1:0] wsi_i,
  input  logic [N_WIRES-1:0] enable_i,
  output logic               irq_o,
  input  logic               claim_i,
  output logic               claim_valid_o,
  output logic [ID_W-1:0]    claim_id_o,
  input  logic               complete_i,
  input  logic [ID_W-1:0]    complete_id_i,
  output logic               complete_err_o
);

  logic [N_WIRES-1:0] wsi_q;
  logic [N_WIRES-1:0] pending;
  logic [N_WIRES-1:0] in_service;
  logic [N_WIRES-1:0] eligible;
  logic [N_WIRES-1:0] claim_hit;
  logic [N_WIRES-1:0] complete_hit;
  logic [ID_W-1:0]    sel_id;
  logic               complete_bad;

`ifdef IOMMU_WSI_GW_SYNC_EN
  logic [N_WIRES-1:0] wsi_meta;
  logic [N_WIRES-1:0] wsi_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wsi_meta <= '0;
      wsi_sync <= '0;
      wsi_q    <= '0;
    end else begin
      wsi_meta <= wsi_i;
      wsi_sync <= wsi_meta;
      wsi_q    <= wsi_sync;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) wsi_q <= '0;
    else       wsi_q <= wsi_i;
  end
`endif

  assign eligible = pending & enable_i;

  // Downward scan so the lowest eligible index wins.
  always_comb begin
    sel_id    = '0;
    claim_hit = '0;
    for (int i = N_WIRES - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = ID_W'(i + 1);
    end
    for (int i = 0; i < N_WIRES; i++) begin
      claim_hit[i] = claim_i && (sel_id == ID_W'(i + 1));
    end
  end

  // Out-of-range IDs and ID 0 match no cell, which makes them errors for free.
  always_comb begin
    complete_hit = '0;
    for (int i = 0; i < N_WIRES; i++) begin
      complete_hit[i] = complete_i && (complete_id_i == ID_W'(i + 1)) && in_service[i];
    end
    complete_bad = complete_i && !(|complete_hit);
  end

  for (genvar g = 0; g < N_WIRES; g++) begin : g_cell
    iommu_wsi_gw_cell u_cell (
      .clk          (clk_i),
      .rst          (rst_i),
      .level        (wsi_q[g]),
      .claim_hit    (claim_hit[g]),
      .complete_hit (complete_hit[g]),
      .pending      (pending[g]),
      .in_service   (in_service[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o          <= 1'b0;
      claim_valid_o  <= 1'b0;
      claim_id_o     <= '0;
      complete_err_o <= 1'b0;
    end else begin
      irq_o          <= |eligible;
      claim_valid_o  <= claim_i;
      complete_err_o <= complete_bad;
      if (claim_i) claim_id_o <= sel_id;
    end
  end

endmodule
